layer6_pixel_store: RTL and testbench

LAYER6_PIXEL_STORE -- requirements
Module: layer6_pixel_store

---
 rtl/layer6_pixel_store_pkg.sv | 19 +
 rtl/pixel_ram_1r1w.sv | 21 ++
 rtl/layer6_pixel_store.sv | 63 ++++++
 tb/tb_layer6_pixel_store.sv | 136 +++++++++++++
 4 files changed

// File: rtl/layer6_pixel_store_pkg.sv
// layer6_pixel_store_pkg: shared word sizes, layer-6 geometry and store state encoding
package layer6_pixel_store_pkg;
  localparam int WORDLENGTH = 16;
  localparam int LAYER6_CHANNELS = 8;
  localparam int LAYER6_WIDTH = 16;
  localparam int LAYER6_DATA_W = LAYER6_CHANNELS * WORDLENGTH;
  localparam int ADDR_W = 16;
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DONE  = 2'd1,
    ST_SERVE = 2'd2
  } state_t;
  function automatic logic [ADDR_W-1:0] pixel_addr(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col, input logic [ADDR_W-1:0] w);
    return row * w + col;
  endfunction
  function automatic logic in_map(input logic [ADDR_W-1:0] row, input logic [ADDR_W-1:0] col, input logic [ADDR_W-1:0] w);
    return (row < w) && (col < w);
  endfunction
endpackage

// File: rtl/pixel_ram_1r1w.sv
// pixel_ram_1r1w: synchronous one-write/one-read array with registered read data
module pixel_ram_1r1w #(
  parameter int DEPTH = 256,
  parameter int DATA_W = 128,
  parameter int AW = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // write port and registered read port; read data holds when re is low
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/layer6_pixel_store.sv
// layer6_pixel_store: buffers a full layer-6 feature map and serves it to the pooling layer
module layer6_pixel_store
  import layer6_pixel_store_pkg::*;
#(
  parameter int WIDTH = LAYER6_WIDTH,
  parameter int DATA_W = LAYER6_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [15:0]       save_row,
  input  logic [15:0]       save_col,
  input  logic [DATA_W-1:0] save_data,
  output logic              pixel_store_done,
  input  logic              read_pixel_signal,
  input  logic [15:0]       read_row_addr,
  input  logic [15:0]       read_col_addr,
  output logic [DATA_W-1:0] output_data,
  input  logic              layer6_calculation_done
);
  localparam int DEPTH = WIDTH * WIDTH;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] W = ADDR_W'(WIDTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WIDTH - 1);
  state_t state, state_nx;
  logic wr_ok, rd_ok, rd_hit, last_wr;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [DATA_W-1:0] ram_q;
  logic unused_addr_bits;
  assign waddr = pixel_addr(save_row, save_col, W);
  assign raddr = pixel_addr(read_row_addr, read_col_addr, W);
  assign unused_addr_bits = ^{waddr, raddr};
  assign wr_ok = (state == ST_FILL) && save_enable && in_map(save_row, save_col, W);
  assign rd_ok = (state != ST_FILL) && read_pixel_signal && in_map(read_row_addr, read_col_addr, W);
  assign last_wr = wr_ok && (save_row == LAST) && (save_col == LAST);
  assign pixel_store_done = (state == ST_DONE);
  assign output_data = rd_hit ? ram_q : '0;
  // fill until the last pixel lands, announce for one cycle, then serve until released
  always_comb begin
    state_nx = (state == ST_FILL) ? (last_wr ? ST_DONE : ST_FILL) :
               (state == ST_DONE) ? ST_SERVE :
               (layer6_calculation_done ? ST_FILL : ST_SERVE);
  end
  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FILL;
    else state <= state_nx;
  end
  // remembers whether the last strobed read was valid; an invalid one forces zero out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_hit <= 1'b0;
    else if (read_pixel_signal) rd_hit <= rd_ok;
  end
  pixel_ram_1r1w #(.DEPTH(DEPTH), .DATA_W(DATA_W), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (waddr[AW-1:0]),
    .wdata (save_data),
    .re    (rd_ok),
    .raddr (raddr[AW-1:0]),
    .rdata (ram_q)
  );
endmodule

// File: tb/tb_layer6_pixel_store.sv
// tb_layer6_pixel_store: directed checks of fill, serve, release and reset behaviour
module tb_layer6_pixel_store;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic save_enable = 1'b0;
  logic [15:0] save_row = '0, save_col = '0;
  logic [127:0] save_data = '0;
  logic pixel_store_done;
  logic read_pixel_signal = 1'b0;
  logic [15:0] read_row_addr = '0, read_col_addr = '0;
  logic [127:0] output_data;
  logic layer6_calculation_done = 1'b0;
  int errs = 0;
  int checks = 0;
  int pulses = 0;

  layer6_pixel_store #(.WIDTH(4), .DATA_W(128)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .save_enable             (save_enable),
    .save_row                (save_row),
    .save_col                (save_col),
    .save_data               (save_data),
    .pixel_store_done        (pixel_store_done),
    .read_pixel_signal       (read_pixel_signal),
    .read_row_addr           (read_row_addr),
    .read_col_addr           (read_col_addr),
    .output_data             (output_data),
    .layer6_calculation_done (layer6_calculation_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (pixel_store_done) pulses <= pulses + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wr(input int r, input int c, input logic [127:0] d);
    save_enable = 1'b1;
    save_row = 16'(r);
    save_col = 16'(c);
    save_data = d;
    @(negedge clk);
    save_enable = 1'b0;
  endtask

  task automatic rd(input int r, input int c);
    read_pixel_signal = 1'b1;
    read_row_addr = 16'(r);
    read_col_addr = 16'(c);
    @(negedge clk);
    read_pixel_signal = 1'b0;
  endtask

  task automatic fill(input int off, input bit skip0);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!(skip0 && r == 0 && c == 0)) wr(r, c, 128'(r * 4 + c + off));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_out", output_data, 128'd0);
    check("reset_done", {127'd0, pixel_store_done}, 128'd0);
    rst = 1'b1;
    wr(4, 0, 128'd99);
    check("oor_write_no_done", {127'd0, pixel_store_done}, 128'd0);
    fill(0, 1'b0);
    check("fill_done_high", {127'd0, pixel_store_done}, 128'd1);
    rd(3, 3);
    check("read_in_done", output_data, 128'd15);
    check("done_one_cycle", {127'd0, pixel_store_done}, 128'd0);
    check("fill_pulses", 128'(pulses), 128'd1);
    rd(2, 1);
    check("read_2_1", output_data, 128'd9);
    @(negedge clk);
    check("hold_2_1", output_data, 128'd9);
    rd(0, 5);
    check("oor_read", output_data, 128'd0);
    wr(0, 0, 128'hFF);
    rd(0, 0);
    check("locked_write", output_data, 128'd0);
    layer6_calculation_done = 1'b1;
    read_pixel_signal = 1'b1;
    read_row_addr = 16'd1;
    read_col_addr = 16'd1;
    save_enable = 1'b1;
    save_row = 16'd0;
    save_col = 16'd0;
    save_data = 128'hAA;
    @(negedge clk);
    layer6_calculation_done = 1'b0;
    read_pixel_signal = 1'b0;
    save_enable = 1'b0;
    check("release_read", output_data, 128'd5);
    rd(1, 1);
    check("read_in_fill", output_data, 128'd0);
    fill(100, 1'b1);
    check("refill_done_high", {127'd0, pixel_store_done}, 128'd1);
    layer6_calculation_done = 1'b1;
    rd(1, 1);
    layer6_calculation_done = 1'b0;
    check("read_with_release_in_done", output_data, 128'd105);
    check("refill_pulses", 128'(pulses), 128'd2);
    rd(0, 0);
    check("release_write_ignored", output_data, 128'd0);
    rd(3, 2);
    check("still_serving", output_data, 128'd114);
    layer6_calculation_done = 1'b1;
    @(negedge clk);
    layer6_calculation_done = 1'b0;
    check("release_hold", output_data, 128'd114);
    for (int i = 0; i < 8; i++) wr(i / 4, i % 4, 128'(i + 200));
    #2 rst = 1'b0;
    #1 check("midfill_reset_out", output_data, 128'd0);
    check("midfill_reset_done", {127'd0, pixel_store_done}, 128'd0);
    @(negedge clk);
    rst = 1'b1;
    check("midfill_no_pulse", 128'(pulses), 128'd2);
    fill(200, 1'b0);
    @(negedge clk);
    check("post_reset_pulses", 128'(pulses), 128'd3);
    rd(2, 2);
    check("post_reset_read", output_data, 128'd210);
    repeat (3) @(negedge clk);
    check("final_pulses", 128'(pulses), 128'd3);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
